// File: rtl/serdes_link_align_ctrl_pkg.sv
// Shared definitions for the SERDES word-alignment controller: state codes,
// default training word and the registered control-output bundle.
package serdes_link_align_ctrl_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RECAL    = 3'd1;
    localparam logic [2:0] ST_WAIT_CAL = 3'd2;
    localparam logic [2:0] ST_CHECK    = 3'd3;
    localparam logic [2:0] ST_SLIP     = 3'd4;
    localparam logic [2:0] ST_SETTLE   = 3'd5;
    localparam logic [2:0] ST_LOCKED   = 3'd6;
    localparam logic [2:0] ST_FAIL     = 3'd7;

    localparam logic [7:0] TRAIN_PAT_DEF = 8'hBC;

    typedef struct packed {
        logic recal;
        logic calib;
        logic link_up;
        logic align_err;
    } ctrl_out_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counter width that can hold n-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic ctrl_out_t decode_state(input logic [2:0] st);
        ctrl_out_t o;
        o           = '0;
        o.recal     = (st == ST_RECAL);
        o.calib     = (st == ST_SLIP);
        o.link_up   = (st == ST_LOCKED);
        o.align_err = (st == ST_FAIL);
        return o;
    endfunction

endpackage

// File: rtl/serdes_link_align_ctrl_if.sv
// Link-side signal bundle between the SERDES wrapper / PCS and the alignment controller.
interface serdes_link_align_ctrl_if;

    logic       en;
    logic       cal;
    logic [7:0] rx_dat;
    logic       recal;
    logic       calib;
    logic       link_up;
    logic       align_err;
    logic [2:0] slip_cnt;
    logic [2:0] state_o;

    modport master (
        output en, cal, rx_dat,
        input  recal, calib, link_up, align_err, slip_cnt, state_o
    );

    modport slave (
        input  en, cal, rx_dat,
        output recal, calib, link_up, align_err, slip_cnt, state_o
    );

endinterface

// File: rtl/serdes_link_align_ctrl_run_cnt.sv
// Consecutive-event counter: clear, increment, and a flag when the count reaches TERM-1.
module serdes_link_align_ctrl_run_cnt
    import serdes_link_align_ctrl_pkg::*;
#(
    parameter int unsigned TERM = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_term_c
);

    localparam int unsigned   CW      = clog2_min1(TERM);
    localparam logic [CW-1:0] CNT_TOP = CW'(TERM - 1);

    logic [CW-1:0] r_cnt;

    // Holds at the terminal value rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CNT_TOP)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_term_c = (r_cnt == CNT_TOP);

endmodule

// File: rtl/serdes_link_align_ctrl.sv
// SERDES receive word-alignment sequencer: recal the delay line, wait for lock,
// bit-slip until the training word is seen, then supervise the locked link.
module serdes_link_align_ctrl
    import serdes_link_align_ctrl_pkg::*;
#(
    parameter logic [7:0]  TRAIN_PAT = TRAIN_PAT_DEF,
    parameter int unsigned RECAL_LEN = 4,
    parameter int unsigned CAL_TMO   = 1024,
    parameter int unsigned SLIP_WAIT = 8,
    parameter int unsigned LOCK_CNT  = 16,
    parameter int unsigned LOSS_CNT  = 4,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                    pclk,
    input  logic                    Rs,
    serdes_link_align_ctrl_if.slave bus
);

    localparam int unsigned   TW          = clog2_min1(max3(CAL_TMO, SLIP_WAIT, RECAL_LEN));
    localparam int unsigned   RW          = clog2_min1(MAX_RETRY);
    localparam logic [TW-1:0] RECAL_LAST  = TW'(RECAL_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(CAL_TMO - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SLIP_WAIT - 1);
    localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY - 1);
    localparam logic [2:0]    SLIP_LAST   = 3'd7;

    logic [2:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [RW-1:0] r_retry;
    logic [2:0]    r_slip;

    logic [2:0]    w_state_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic [RW-1:0] w_retry_nxt;
    logic [2:0]    w_slip_nxt;

    logic          w_match;
    logic          w_retry_fail;
    logic          w_match_clr;
    logic          w_match_inc;
    logic          w_match_term;
    logic          w_err_clr;
    logic          w_err_inc;
    logic          w_err_term;

    ctrl_out_t     r_out;
    logic [2:0]    r_slip_o;
    logic [2:0]    r_state_o;

    assign w_match      = (bus.rx_dat == TRAIN_PAT);
    assign w_retry_fail = (r_retry == RETRY_LAST);

    serdes_link_align_ctrl_run_cnt #(.TERM(LOCK_CNT)) u_match_cnt (
        .clk      (pclk),
        .rst      (Rs),
        .i_clr    (w_match_clr),
        .i_inc    (w_match_inc),
        .o_term_c (w_match_term)
    );

    serdes_link_align_ctrl_run_cnt #(.TERM(LOSS_CNT)) u_err_cnt (
        .clk      (pclk),
        .rst      (Rs),
        .i_clr    (w_err_clr),
        .i_inc    (w_err_inc),
        .o_term_c (w_err_term)
    );

    // State register together with the timer, retry and slip counters.
    always_ff @(posedge pclk) begin
        if (Rs) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_retry <= '0;
            r_slip  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_retry <= w_retry_nxt;
            r_slip  <= w_slip_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_retry_nxt = r_retry;
        w_slip_nxt  = r_slip;
        w_match_clr = 1'b0;
        w_match_inc = 1'b0;
        w_err_clr   = 1'b0;
        w_err_inc   = 1'b0;

        if (!bus.en) begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
            w_retry_nxt = '0;
            w_slip_nxt  = '0;
            w_match_clr = 1'b1;
            w_err_clr   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_RECAL;
                    w_timer_nxt = '0;
                    w_retry_nxt = '0;
                end
                ST_RECAL: begin
                    if (r_timer == RECAL_LAST) begin
                        w_state_nxt = ST_WAIT_CAL;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
                ST_WAIT_CAL: begin
                    if (bus.cal) begin
                        w_state_nxt = ST_CHECK;
                        w_slip_nxt  = '0;
                        w_match_clr = 1'b1;
                    end else if (r_timer == TMO_LAST) begin
                        w_state_nxt = w_retry_fail ? ST_FAIL : ST_RECAL;
                        w_retry_nxt = w_retry_fail ? r_retry : r_retry + RW'(1);
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
                ST_CHECK: begin
                    if (w_match) begin
                        if (w_match_term) begin
                            w_state_nxt = ST_LOCKED;
                            w_err_clr   = 1'b1;
                            w_retry_nxt = '0;
                        end else begin
                            w_match_inc = 1'b1;
                        end
                    end else if (r_slip != SLIP_LAST) begin
                        w_state_nxt = ST_SLIP;
                    end else begin
                        // Every bit phase tried without a match: treat as a failed attempt.
                        w_state_nxt = w_retry_fail ? ST_FAIL : ST_RECAL;
                        w_retry_nxt = w_retry_fail ? r_retry : r_retry + RW'(1);
                        w_timer_nxt = '0;
                    end
                end
                ST_SLIP: begin
                    w_state_nxt = ST_SETTLE;
                    w_slip_nxt  = r_slip + 3'd1;
                    w_timer_nxt = '0;
                end
                ST_SETTLE: begin
                    if (r_timer == SETTLE_LAST) begin
                        w_state_nxt = ST_CHECK;
                        w_match_clr = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!bus.cal) begin
                        w_state_nxt = ST_RECAL;
                        w_timer_nxt = '0;
                    end else if (!w_match) begin
                        if (w_err_term) begin
                            w_state_nxt = ST_RECAL;
                            w_timer_nxt = '0;
                        end else begin
                            w_err_inc = 1'b1;
                        end
                    end else begin
                        w_err_clr = 1'b1;
                    end
                end
                ST_FAIL: begin
                    w_state_nxt = ST_FAIL;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Moore outputs one cycle behind the state; en low blanks them at once so no stray pulse escapes.
    always_ff @(posedge pclk) begin
        if (Rs || !bus.en) begin
            r_out     <= '0;
            r_slip_o  <= '0;
            r_state_o <= ST_IDLE;
        end else begin
            r_out     <= decode_state(r_state);
            r_slip_o  <= r_slip;
            r_state_o <= r_state;
        end
    end

    assign bus.recal     = r_out.recal;
    assign bus.calib     = r_out.calib;
    assign bus.link_up   = r_out.link_up;
    assign bus.align_err = r_out.align_err;
    assign bus.slip_cnt  = r_slip_o;
    assign bus.state_o   = r_state_o;

endmodule

// File: tb/tb_serdes_link_align_ctrl.sv
// Bench for serdes_link_align_ctrl: expected output events are queued with their
// cycle when stimulus is applied and matched against edges seen on the DUT outputs.
module tb_serdes_link_align_ctrl;
    import serdes_link_align_ctrl_pkg::*;

    localparam int EV_ERR_UP   = 1;
    localparam int EV_ERR_DN   = 2;
    localparam int EV_LINK_UP  = 3;
    localparam int EV_LINK_DN  = 4;
    localparam int EV_RECAL_UP = 5;
    localparam int EV_RECAL_DN = 6;
    localparam int EV_CALIB    = 7;

    typedef struct {
        int kind;
        int cyc;
        int slip;
    } ev_t;

    logic pclk = 1'b0;
    logic Rs;

    serdes_link_align_ctrl_if bus ();

    serdes_link_align_ctrl dut (
        .pclk (pclk),
        .Rs   (Rs),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

    ev_t        sb[$];
    int         n_chk     = 0;
    int         n_err     = 0;
    int         cyc       = 0;
    logic       p_recal   = 1'b0;
    logic       p_calib   = 1'b0;
    logic       p_link    = 1'b0;
    logic       p_err     = 1'b0;
    logic [2:0] calib_cnt = 3'd0;
    logic [2:0] phase_ofs = 3'd0;
    logic       rx_model  = 1'b1;
    logic [7:0] rx_fixed  = 8'hBC;

    function automatic logic [7:0] rotl(input logic [7:0] w, input logic [2:0] n);
        logic [15:0] d;
        d = {w, w} << n;
        return d[15:8];
    endfunction

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int at, input int slip);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        e.slip = slip;
        sb.push_back(e);
    endtask

    // Recal entered at edge r: pulse visible after r+1, gone after r+RECAL_LEN+1.
    task automatic push_recal(input int r);
        push(EV_RECAL_UP, r + 1, -1);
        push(EV_RECAL_DN, r + 5, -1);
    endtask

    task automatic observe(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            chk("ev_unexpected", kind, 0);
            return;
        end
        e = sb.pop_front();
        chk("ev_kind", kind, e.kind);
        chk($sformatf("ev%0d_cycle", e.kind), cyc, e.cyc);
        if (e.slip >= 0) chk("ev_slip_cnt", int'(bus.slip_cnt), e.slip);
    endtask

    task automatic apply_rx();
        if (rx_model) bus.rx_dat = rotl(TRAIN_PAT_DEF, phase_ofs + calib_cnt);
        else          bus.rx_dat = rx_fixed;
    endtask

    task automatic monitor();
        if (bus.align_err != p_err)  observe(bus.align_err ? EV_ERR_UP : EV_ERR_DN);
        if (bus.link_up != p_link)   observe(bus.link_up ? EV_LINK_UP : EV_LINK_DN);
        if (bus.recal != p_recal)    observe(bus.recal ? EV_RECAL_UP : EV_RECAL_DN);
        if (bus.calib) begin
            chk("calib_back_to_back", int'(p_calib), 0);
            observe(EV_CALIB);
            calib_cnt = calib_cnt + 3'd1;
        end
        p_err   = bus.align_err;
        p_link  = bus.link_up;
        p_recal = bus.recal;
        p_calib = bus.calib;
    endtask

    // One clock: count the edge, sample outputs at the falling edge, then update the SERDES model.
    task automatic tick();
        @(posedge pclk);
        #1;
        cyc++;
        @(negedge pclk);
        monitor();
        apply_rx();
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("sb_drain_pending", sb.size(), 0);
        if (sb.size() != 0) sb.delete();
    endtask

    task automatic go_idle(input bit link_was_up, input bit err_was_up);
        bus.en = 1'b0;
        if (err_was_up)  push(EV_ERR_DN, cyc + 1, -1);
        if (link_was_up) push(EV_LINK_DN, cyc + 1, -1);
        tick();
        chk("idle_state", int'(bus.state_o), 0);
        tick();
    endtask

    initial begin
        int k;
        int r;
        int e;
        int t;
        int u;

        Rs         = 1'b1;
        bus.en     = 1'b0;
        bus.cal    = 1'b0;
        bus.rx_dat = 8'hBC;
        repeat (3) tick();
        chk("rst_recal",     int'(bus.recal),     0);
        chk("rst_calib",     int'(bus.calib),     0);
        chk("rst_link_up",   int'(bus.link_up),   0);
        chk("rst_align_err", int'(bus.align_err), 0);
        chk("rst_slip_cnt",  int'(bus.slip_cnt),  0);
        chk("rst_state",     int'(bus.state_o),   0);

        // Clean bring-up: cal arrives 20 cycles after enable, word already aligned.
        Rs     = 1'b0;
        bus.en = 1'b1;
        k      = cyc;
        push_recal(k + 1);
        repeat (20) tick();
        bus.cal = 1'b1;
        push(EV_LINK_UP, cyc + 18, 0);
        wait_drain(40);
        tick();
        chk("t1_state_locked", int'(bus.state_o), 6);
        chk("t1_slip_cnt",     int'(bus.slip_cnt), 0);

        Rs = 1'b1;
        push(EV_LINK_DN, cyc + 1, -1);
        tick();
        chk("midrst_state", int'(bus.state_o), 0);
        Rs      = 1'b0;
        bus.en  = 1'b0;
        bus.cal = 1'b0;
        tick();
        tick();

        // Word lands three slips away from alignment.
        phase_ofs = 3'd5 - calib_cnt;
        apply_rx();
        bus.cal = 1'b1;
        bus.en  = 1'b1;
        k       = cyc;
        push_recal(k + 1);
        e = k + 6;
        for (int j = 0; j < 3; j++) push(EV_CALIB, e + 2 + 10 * j, -1);
        push(EV_LINK_UP, e + 47, 3);
        wait_drain(80);
        tick();
        chk("t2_state_locked", int'(bus.state_o), 6);

        // Three bad words then a good one keep the link; four bad words drop it.
        rx_model = 1'b0;
        rx_fixed = 8'h00;
        apply_rx();
        repeat (3) tick();
        rx_fixed = 8'hBC;
        apply_rx();
        repeat (4) tick();
        chk("t4_link_held", int'(bus.link_up), 1);
        u        = cyc;
        rx_fixed = 8'h00;
        apply_rx();
        push(EV_LINK_DN,  u + 5,  -1);
        push(EV_RECAL_UP, u + 5,  -1);
        push(EV_RECAL_DN, u + 9,  -1);
        push(EV_LINK_UP,  u + 26, 0);
        repeat (4) tick();
        rx_fixed = 8'hBC;
        apply_rx();
        wait_drain(40);

        // One-cycle cal drop while locked.
        tick();
        t       = cyc;
        bus.cal = 1'b0;
        push(EV_LINK_DN,  t + 2,  -1);
        push(EV_RECAL_UP, t + 2,  -1);
        push(EV_RECAL_DN, t + 6,  -1);
        push(EV_LINK_UP,  t + 23, 0);
        tick();
        bus.cal = 1'b1;
        tick();
        chk("t5_state_recal", int'(bus.state_o), 1);
        wait_drain(40);

        // Enable dropped while the FSM sits in SLIP.
        go_idle(1'b1, 1'b0);
        rx_fixed = 8'h00;
        apply_rx();
        bus.en = 1'b1;
        k      = cyc;
        push_recal(k + 1);
        repeat (7) tick();
        bus.en = 1'b0;
        tick();
        chk("t5_en_drop_calib", int'(bus.calib),    0);
        chk("t5_en_drop_state", int'(bus.state_o),  0);
        chk("t5_en_drop_slip",  int'(bus.slip_cnt), 0);
        tick();
        wait_drain(4);

        // Pattern never present: seven slips per attempt, three attempts, then FAIL.
        bus.en = 1'b1;
        k      = cyc;
        r      = k + 1;
        for (int a = 0; a < 3; a++) begin
            push_recal(r);
            e = r + 5;
            for (int j = 0; j < 7; j++) push(EV_CALIB, e + 2 + 10 * j, -1);
            if (a < 2) r = e + 71;
            else       push(EV_ERR_UP, e + 72, -1);
        end
        wait_drain(300);
        chk("t6_link_down",  int'(bus.link_up), 0);
        chk("t6_state_fail", int'(bus.state_o), 7);
        go_idle(1'b0, 1'b1);

        // cal never asserts: three timed-out recal attempts, then FAIL.
        bus.cal = 1'b0;
        bus.en  = 1'b1;
        k       = cyc;
        r       = k + 1;
        push_recal(r);
        push_recal(r + 1028);
        push_recal(r + 2056);
        push(EV_ERR_UP, r + 3085, -1);
        wait_drain(3200);
        chk("t3_link_down", int'(bus.link_up), 0);
        tick();
        chk("t3_err_held", int'(bus.align_err), 1);
        go_idle(1'b0, 1'b1);

        chk("sb_leftover", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
